data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Responder end of the CPU data-memory interface: byte-addressed, little-endian data RAM.
//  Serves LB/LH/LW/LBU/LHU reads and SB/SH/SW writes from the MEM stage.
//  Models a multi-cycle memory: asserts BUSYWAIT to stall the pipeline for LATENCY cycles per access.
//  Sits beside cpu; its ports connect 1:1 to DATA_MEM_READ/WRITE/ADDR/WRITE_DATA/READ_DATA/BUSYWAIT.
// PARAMETERS
//  ADDR_WIDTH  10  byte-address bits actually decoded; depth = 2**ADDR_WIDTH bytes (ADDRESS upper bits ignored, wraps)
//  LATENCY     5   ACCESS-state cycles per request; legal range 1..255
// PORTS
//  CLK        in   1   clock, all state updates on posedge
//  RESET      in   1   synchronous, active-high reset
//  READ       in   4   [3]=read enable, [2:0]=funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  WRITE      in   3   [2]=write enable, [1:0]=funct3[1:0]: 00 SB, 01 SH, 10 SW
//  ADDRESS    in   32  byte address (ALU result)
//  WRITEDATA  in   32  store data; SB uses [7:0], SH uses [15:0]
//  READDATA   out  32  load result, extended to 32 bits; registered
//  BUSYWAIT   out  1   high while a request is accepted or in progress; CPU must hold PC/pipeline
//  MISALIGNED out  1   one-cycle pulse in DONE when the completed request was misaligned or illegal
// BEHAVIOUR
//  Reset: state=IDLE, READDATA=0, MISALIGNED=0, counter=0; BUSYWAIT=0 from next cycle. RAM contents NOT cleared.
//  req = READ[3] | WRITE[2].
//  FSM:
//   IDLE:   if req -> latch ADDRESS/WRITEDATA/READ/WRITE, counter<=LATENCY-1, go ACCESS; else stay.
//   ACCESS: counter-- each cycle; at edge with counter==0: perform access, go DONE.
//   DONE:   unconditionally -> IDLE. Request inputs ignored during DONE.
//  BUSYWAIT (combinational) = (IDLE & req) | ACCESS. Low in DONE.
//  Timeline (req appears in cycle 0): BUSYWAIT high cycles 0..LATENCY (LATENCY+1 cycles).
//   DONE is cycle LATENCY+1: BUSYWAIT=0 and READDATA valid; CPU advances at end of DONE.
//  Only latched request fields are used; input changes during ACCESS are ignored.
//  Read extension:
//   LB/LH sign-extend from bit 7/15.
//   LBU/LHU zero-extend.
//   LW returns bytes [a+3,a+2,a+1,a] as {b3,b2,b1,b0}.
//  Writes update only the addressed bytes; other bytes unchanged. READDATA holds its previous value after a write.
//  Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
//   Misaligned read -> READDATA=0. Misaligned write -> no RAM update. MISALIGNED=1 in DONE.
//  Illegal: undefined funct3 (READ[2:0] in 011/110/111, WRITE[1:0]=11) -> same handling as misaligned.
//   READ[3] & WRITE[2] together -> also illegal: no RAM update, READDATA=0, MISALIGNED pulse.
//  Address wrap: only ADDRESS[ADDR_WIDTH-1:0] decoded. Word at depth-2 wraps bytes to 0/1 (only reachable if misaligned, so rejected).
//  Back-to-back: a request held continuously re-triggers only after DONE->IDLE. A new request restarts the full LATENCY.
//  RESET during ACCESS aborts the access (no RAM write); IDLE next cycle.
//  LATENCY=1: BUSYWAIT high 2 cycles (IDLE accept + one ACCESS cycle).
// TESTING (LATENCY=5, ADDR_WIDTH=10)
//  1 SW 0xDEADBEEF @0x10, then LW @0x10 -> BUSYWAIT high exactly 6 cycles each; READDATA=0xDEADBEEF in DONE.
//  2 After 1: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
//  3 SB 0x12345655 @0x11, SH 0xAAAA0102 @0x12, LW @0x10 -> 0x010255EF.
//  4 LW @0x12 -> MISALIGNED pulse, READDATA=0; SW @0x11 -> MISALIGNED pulse, LW @0x10 still 0x010255EF.
//  5 SW 0xFFFFFFFF @0x20, RESET in 3rd ACCESS cycle -> BUSYWAIT=0 next cycle, LW @0x20 returns prior contents.
//  6 Request held through DONE -> second access starts only in IDLE; ADDRESS 0x400 aliases 0x000.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: byte-addressed, little-endian data RAM serving CPU loads and stores.
// Latency: BUSYWAIT high for LATENCY+1 cycles per request; the result is valid in the following DONE cycle.
// Backpressure: BUSYWAIT stalls the CPU; request inputs are sampled only in IDLE and ignored in ACCESS and DONE.
module data_memory #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  READ,
   input  logic [2:0]  WRITE,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITEDATA,
   output logic [31:0] READDATA,
   output logic        BUSYWAIT,
   output logic        MISALIGNED
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                state;
   logic [7:0]            counter;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [31:0]           lat_wdata;
   logic [3:0]            lat_read;
   logic [2:0]            lat_write;

   logic [7:0]            mem [0:DEPTH-1];

   logic                  req;
   logic                  finish;
   logic                  rd_en;
   logic                  wr_en;
   logic                  rd_bad;
   logic                  wr_bad;
   logic                  bad;
   logic [ADDR_WIDTH-1:0] a1;
   logic [ADDR_WIDTH-1:0] a2;
   logic [ADDR_WIDTH-1:0] a3;
   logic [7:0]            b0;
   logic [7:0]            b1;
   logic [7:0]            b2;
   logic [7:0]            b3;
   logic [31:0]           load_val;
   logic                  unused_addr_hi;

   // Address bits above the decoded range are deliberately ignored (the RAM wraps).
   assign unused_addr_hi = &{1'b0, ADDRESS[31:ADDR_WIDTH]};

   assign req      = READ[3] | WRITE[2];
   assign finish   = (state == ACCESS) && (counter == 8'd0);
   assign BUSYWAIT = ((state == IDLE) && req) || (state == ACCESS);

   // Decode the latched request: byte lanes, alignment/legality, and the extended load value.
   always_comb begin
      rd_en = lat_read[3];
      wr_en = lat_write[2];
      a1    = lat_addr + ADDR_WIDTH'(1);
      a2    = lat_addr + ADDR_WIDTH'(2);
      a3    = lat_addr + ADDR_WIDTH'(3);
      b0    = mem[lat_addr];
      b1    = mem[a1];
      b2    = mem[a2];
      b3    = mem[a3];

      case (lat_read[2:0])
         3'b000, 3'b100: rd_bad = 1'b0;
         3'b001, 3'b101: rd_bad = lat_addr[0];
         3'b010:         rd_bad = (lat_addr[1:0] != 2'b00);
         default:        rd_bad = 1'b1;
      endcase

      case (lat_write[1:0])
         2'b00:   wr_bad = 1'b0;
         2'b01:   wr_bad = lat_addr[0];
         2'b10:   wr_bad = (lat_addr[1:0] != 2'b00);
         default: wr_bad = 1'b1;
      endcase

      // A request asserting both read and write is never legal.
      bad = (rd_en & wr_en) | (rd_en & rd_bad) | (wr_en & wr_bad);

      case (lat_read[2:0])
         3'b000:  load_val = {{24{b0[7]}}, b0};
         3'b001:  load_val = {{16{b1[7]}}, b1, b0};
         3'b010:  load_val = {b3, b2, b1, b0};
         3'b100:  load_val = {24'h000000, b0};
         3'b101:  load_val = {16'h0000, b1, b0};
         default: load_val = 32'h0000_0000;
      endcase
   end

   // Request FSM: accept in IDLE, count down in ACCESS, present results for one DONE cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         counter    <= 8'd0;
         READDATA   <= 32'h0000_0000;
         MISALIGNED <= 1'b0;
      end else begin
         MISALIGNED <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  lat_addr  <= ADDRESS[ADDR_WIDTH-1:0];
                  lat_wdata <= WRITEDATA;
                  lat_read  <= READ;
                  lat_write <= WRITE;
                  counter   <= 8'(LATENCY - 1);
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (counter == 8'd0) begin
                  state      <= DONE;
                  MISALIGNED <= bad;
                  // Write-only requests leave READDATA untouched.
                  if (rd_en) begin
                     READDATA <= bad ? 32'h0000_0000 : load_val;
                  end
               end else begin
                  counter <= counter - 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Byte-lane RAM update at the end of the last ACCESS cycle; a reset at that edge aborts it.
   always_ff @(posedge CLK) begin
      if (!RESET && finish && wr_en && !bad) begin
         mem[lat_addr] <= lat_wdata[7:0];
         if (lat_write[1:0] != 2'b00) begin
            mem[a1] <= lat_wdata[15:8];
         end
         if (lat_write[1:0] == 2'b10) begin
            mem[a2] <= lat_wdata[23:16];
            mem[a3] <= lat_wdata[31:24];
         end
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed vector table, hand-written multi-cycle sequences and a randomized
// phase compared against a byte-array reference model of the load/store rules.
module tb_data_memory;

   localparam int LAT     = 5;
   localparam int BUSY_EX = LAT + 1;

   logic        CLK;
   logic        RESET;
   logic [3:0]  READ;
   logic [2:0]  WRITE;
   logic [31:0] ADDRESS;
   logic [31:0] WRITEDATA;
   logic [31:0] READDATA;
   logic        BUSYWAIT;
   logic        MISALIGNED;

   int n_cmp = 0;
   int n_mis = 0;

   data_memory #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .READ       (READ),
      .WRITE      (WRITE),
      .ADDRESS    (ADDRESS),
      .WRITEDATA  (WRITEDATA),
      .READDATA   (READDATA),
      .BUSYWAIT   (BUSYWAIT),
      .MISALIGNED (MISALIGNED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout required completion");
      $fatal(1);
   end

   typedef struct {
      logic [3:0]  rd;
      logic [2:0]  wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[20];

   // reference model state: random-phase region 0x100..0x13F and last READDATA
   logic [7:0]  ref_mem [0:63];
   logic [31:0] ref_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Issue one request at a negedge, count BUSYWAIT cycles, capture outputs in DONE.
   task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                         input logic [31:0] wd, output int busy,
                         output logic [31:0] rdat, output logic mis);
      @(negedge CLK);
      READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
      busy = 0;
      #2;
      while (BUSYWAIT && busy < 400) begin
         busy++;
         @(negedge CLK);
         #2;
      end
      rdat = READDATA;
      mis  = MISALIGNED;
      READ = 4'h0; WRITE = 3'b000;
   endtask

   // Reference model: applies the load/store rules to the byte array.
   task automatic model(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] er, output logic em);
      int     off;
      int     f;
      int     sz;
      bit     sgn;
      longint v;
      off = int'(a[9:0]) - 256;
      er  = ref_rd;
      em  = 1'b0;
      if (rd[3] && wr[2]) begin
         em = 1'b1; er = 32'h0;
      end else if (rd[3]) begin
         f   = int'(rd[2:0]);
         sz  = (f == 0 || f == 4) ? 1 : (f == 1 || f == 5) ? 2 : (f == 2) ? 4 : 0;
         sgn = (f < 4);
         if (sz == 0 || (off % sz) != 0) begin
            em = 1'b1; er = 32'h0;
         end else begin
            v = 0;
            for (int i = 0; i < sz; i++) v += longint'(ref_mem[off + i]) << (8 * i);
            if (sgn && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
            er = v[31:0];
         end
      end else if (wr[2]) begin
         sz = (wr[1:0] == 2'b11) ? 0 : (1 << wr[1:0]);
         if (sz == 0 || (off % sz) != 0) begin
            em = 1'b1;
         end else begin
            for (int i = 0; i < sz; i++) ref_mem[off + i] = 8'((wd >> (8 * i)) & 32'hFF);
         end
      end
      ref_rd = er;
   endtask

   initial begin
      int          busy;
      logic [31:0] rdat;
      logic        mis;
      logic [31:0] er;
      logic        em;
      logic [3:0]  rd;
      logic [2:0]  wr;
      logic [31:0] a;
      logic [31:0] wd;
      int          off;
      int          kind;

      vecs[0]  = '{4'h0, 3'b110, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vecs[1]  = '{4'hA, 3'b000, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{4'h8, 3'b000, 32'h013, 32'h0,        32'hFFFFFFDE, 1'b0};
      vecs[3]  = '{4'hC, 3'b000, 32'h013, 32'h0,        32'h000000DE, 1'b0};
      vecs[4]  = '{4'h9, 3'b000, 32'h012, 32'h0,        32'hFFFFDEAD, 1'b0};
      vecs[5]  = '{4'hD, 3'b000, 32'h010, 32'h0,        32'h0000BEEF, 1'b0};
      vecs[6]  = '{4'h0, 3'b100, 32'h011, 32'h12345655, 32'h0000BEEF, 1'b0};
      vecs[7]  = '{4'h0, 3'b101, 32'h012, 32'hAAAA0102, 32'h0000BEEF, 1'b0};
      vecs[8]  = '{4'hA, 3'b000, 32'h010, 32'h0,        32'h010255EF, 1'b0};
      vecs[9]  = '{4'hA, 3'b000, 32'h012, 32'h0,        32'h00000000, 1'b1};
      vecs[10] = '{4'h0, 3'b110, 32'h011, 32'h11111111, 32'h00000000, 1'b1};
      vecs[11] = '{4'hA, 3'b000, 32'h010, 32'h0,        32'h010255EF, 1'b0};
      vecs[12] = '{4'h9, 3'b000, 32'h011, 32'h0,        32'h00000000, 1'b1};
      vecs[13] = '{4'hB, 3'b000, 32'h010, 32'h0,        32'h00000000, 1'b1};
      vecs[14] = '{4'hA, 3'b000, 32'h410, 32'h0,        32'h010255EF, 1'b0};
      vecs[15] = '{4'h0, 3'b111, 32'h010, 32'hFFFFFFFF, 32'h010255EF, 1'b1};
      vecs[16] = '{4'hA, 3'b110, 32'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[17] = '{4'hA, 3'b000, 32'h010, 32'h0,        32'h010255EF, 1'b0};
      vecs[18] = '{4'hD, 3'b000, 32'h012, 32'h0,        32'h00000102, 1'b0};
      vecs[19] = '{4'h8, 3'b000, 32'h011, 32'h0,        32'h00000055, 1'b0};

      RESET = 1'b1; READ = 4'h0; WRITE = 3'b000; ADDRESS = 32'h0; WRITEDATA = 32'h0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      #2;
      check("reset_readdata", READDATA, 32'h0);
      check("reset_misaligned", 32'(MISALIGNED), 32'h0);
      check("reset_busywait", 32'(BUSYWAIT), 32'h0);

      // directed vector table
      for (int i = 0; i < 20; i++) begin
         access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, busy, rdat, mis);
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(BUSY_EX));
         check($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rdata);
         check($sformatf("vec%0d_mis", i), 32'(mis), 32'(vecs[i].exp_mis));
      end
      ref_rd = 32'h00000055;

      // reset during the third ACCESS cycle aborts the write
      access(4'h0, 3'b110, 32'h20, 32'h55AA1234, busy, rdat, mis);
      check("pre_abort_busy", 32'(busy), 32'(BUSY_EX));
      check("pre_abort_rdata", rdat, ref_rd);
      @(negedge CLK);
      READ = 4'h0; WRITE = 3'b110; ADDRESS = 32'h20; WRITEDATA = 32'hFFFFFFFF;
      repeat (3) @(negedge CLK);
      #2;
      check("abort_busy_before", 32'(BUSYWAIT), 32'h1);
      RESET = 1'b1; WRITE = 3'b000;
      @(negedge CLK);
      RESET = 1'b0;
      #2;
      check("abort_busy_after", 32'(BUSYWAIT), 32'h0);
      check("abort_readdata", READDATA, 32'h0);
      check("abort_misaligned", 32'(MISALIGNED), 32'h0);
      access(4'hA, 3'b000, 32'h20, 32'h0, busy, rdat, mis);
      check("abort_lw_busy", 32'(busy), 32'(BUSY_EX));
      check("abort_lw_rdata", rdat, 32'h55AA1234);

      // held request re-triggers only after DONE; 0x400 aliases 0x000
      access(4'h0, 3'b110, 32'h000, 32'hCAFEF00D, busy, rdat, mis);
      check("alias_sw_rdata", rdat, 32'h55AA1234);
      @(negedge CLK);
      READ = 4'hA; ADDRESS = 32'h400;
      for (int i = 0; i < 14; i++) begin
         #2;
         check($sformatf("held_busy_c%0d", i), 32'(BUSYWAIT), 32'((i % 7) != 6));
         if ((i % 7) == 6) check($sformatf("held_rdata_c%0d", i), READDATA, 32'hCAFEF00D);
         @(negedge CLK);
      end
      READ = 4'h0;
      ref_rd = 32'hCAFEF00D;

      // randomized phase in region 0x100..0x13F, upper address bits randomized
      for (int w = 0; w < 16; w++) begin
         a  = ($urandom() & 32'hFFFF_FC00) | (32'h100 + 32'(4 * w));
         wd = $urandom();
         model(4'h0, 3'b110, a, wd, er, em);
         access(4'h0, 3'b110, a, wd, busy, rdat, mis);
         check($sformatf("init%0d_busy", w), 32'(busy), 32'(BUSY_EX));
         check($sformatf("init%0d_rdata", w), rdat, er);
      end
      for (int n = 0; n < 150; n++) begin
         kind = int'($urandom_range(0, 9));
         rd = 4'h0; wr = 3'b000;
         if (kind < 5) rd = {1'b1, 3'($urandom_range(0, 7))};
         else if (kind < 9) wr = {1'b1, 2'($urandom_range(0, 3))};
         else begin
            rd = {1'b1, 3'($urandom_range(0, 7))};
            wr = {1'b1, 2'($urandom_range(0, 3))};
         end
         off = int'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) off = off & ~3;
         a  = ($urandom() & 32'hFFFF_FC00) | (32'h100 + 32'(off));
         wd = $urandom();
         model(rd, wr, a, wd, er, em);
         access(rd, wr, a, wd, busy, rdat, mis);
         check($sformatf("rnd%0d_busy", n), 32'(busy), 32'(BUSY_EX));
         check($sformatf("rnd%0d_rdata", n), rdat, er);
         check($sformatf("rnd%0d_mis", n), 32'(mis), 32'(em));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
